// File: rtl/bgm_pkg.sv
// bgm_pkg: shared types and constants for the background-model
// result stream transmitter.
package bgm_pkg;

  localparam int BGM_TDATA_WIDTH = 24;

  localparam logic [1:0] BGM_VIEW_BG   = 2'd0;
  localparam logic [1:0] BGM_VIEW_FG   = 2'd1;
  localparam logic [1:0] BGM_VIEW_MV   = 2'd2;
  localparam logic [1:0] BGM_VIEW_FGMV = 2'd3;

  localparam logic [BGM_TDATA_WIDTH-1:0] BGM_MASK_ONES = '1;

  typedef enum logic {
    SOF_WAIT,
    SOF_STREAM
  } bgm_sof_state_e;

  // Single mask bit for the mask views; BG view yields 0.
  function automatic logic bgm_view_mask(
    input logic [1:0] view,
    input logic       fg,
    input logic       mv
  );
    logic m;
    unique case (view)
      BGM_VIEW_FG: m = fg;
      BGM_VIEW_MV: m = mv;
      BGM_VIEW_FGMV: m = fg & mv;
      default: m = 1'b0;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/bgm_result_stream_tx_if.sv
// bgm_result_stream_tx_if: AXI4-Stream video bundle
// (tvalid/tready handshake plus tdata/tuser/tlast).
interface bgm_result_stream_tx_if
  import bgm_pkg::*;
#(
  parameter int W = BGM_TDATA_WIDTH
);

  logic         tvalid;
  logic         tready;
  logic [W-1:0] tdata;
  logic         tuser;
  logic         tlast;

  modport master (
    output tvalid,
    output tdata,
    output tuser,
    output tlast,
    input  tready
  );

  modport slave (
    input  tvalid,
    input  tdata,
    input  tuser,
    input  tlast,
    output tready
  );

endinterface

// File: rtl/bgm_sync_fifo.sv
// bgm_sync_fifo: first-word-fall-through synchronous FIFO
// with full/empty/count; head entry is always on rd_data_o.
module bgm_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   wr_en_i,
  input  logic [WIDTH-1:0]       wr_data_i,
  input  logic                   rd_en_i,
  output logic [WIDTH-1:0]       rd_data_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] count_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q;
  logic [AW:0]      rd_ptr_q;

  assign count_o   = wr_ptr_q - rd_ptr_q;
  assign empty_o   = (wr_ptr_q == rd_ptr_q);
  assign full_o    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign rd_data_o = mem_q[rd_ptr_q[AW-1:0]];

  // Pointer update on write and on head consumption.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (wr_en_i) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (rd_en_i && !empty_o) rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  // Storage; cleared so the head reads zero out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (wr_en_i) begin
      mem_q[wr_ptr_q[AW-1:0]] <= wr_data_i;
    end
  end

  a_no_overflow: assert property (
    @(posedge clk) disable iff (!rst_n) !(wr_en_i && full_o)
  );

endmodule

// File: rtl/bgm_result_stream_tx.sv
// bgm_result_stream_tx: credit-gated capture of background-model results
// into an AXI4-Stream video output. Option macro: BGM_TX_SOF_ALIGN_EN.
module bgm_result_stream_tx
  import bgm_pkg::*;
#(
  parameter int TDATA_WIDTH = BGM_TDATA_WIDTH,
  parameter int LATENCY     = 4,
  parameter int DEPTH       = 16
) (
  input  logic                   clk,
  input  logic                   aresetn,
  input  logic                   s_tvalid,
  output logic                   s_tready,
  input  logic                   s_tuser,
  input  logic                   s_tlast,
  input  logic [TDATA_WIDTH-1:0] bg_in,
  input  logic [TDATA_WIDTH-1:0] fg_in,
  input  logic [TDATA_WIDTH-1:0] mv_in,
  input  logic [1:0]             view_sel,
  output logic                   m_tvalid,
  input  logic                   m_tready,
  output logic [TDATA_WIDTH-1:0] m_tdata,
  output logic                   m_tuser,
  output logic                   m_tlast
);

  localparam int CW  = $clog2(DEPTH + 1);
  localparam int FW  = TDATA_WIDTH + 2;
  localparam int FCW = $clog2(DEPTH) + 1;

  logic                   s_acc;
  logic                   out_hs;
  logic                   s_tready_q;
  logic [LATENCY-1:0]     sr_v_q;
  logic [LATENCY-1:0]     sr_u_q;
  logic [LATENCY-1:0]     sr_l_q;
  logic                   tap_v;
  logic                   tap_u;
  logic                   tap_l;
  logic                   wr_en;
  logic                   credit_ret;
  logic [CW-1:0]          credit_q;
  logic [CW-1:0]          credit_d;
  logic [1:0]             view_q;
  logic [1:0]             view_d;
  logic [TDATA_WIDTH-1:0] word;
  logic                   fifo_empty;
  logic                   full_unused;
  logic [FCW-1:0]         count_unused;
  logic [FW-1:0]          rd_data;
  logic                   mask_hi_unused;

  assign mask_hi_unused = ^{fg_in[TDATA_WIDTH-1:1],
                            mv_in[TDATA_WIDTH-1:1]};

  assign s_tready = s_tready_q;
  assign s_acc    = s_tvalid & s_tready_q;
  assign m_tvalid = !fifo_empty;
  assign out_hs   = m_tvalid & m_tready;
  assign tap_v    = sr_v_q[LATENCY-1];
  assign tap_u    = sr_u_q[LATENCY-1];
  assign tap_l    = sr_l_q[LATENCY-1];

  // Sideband delay line matching the model latency.
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      sr_v_q <= '0;
      sr_u_q <= '0;
      sr_l_q <= '0;
    end else begin
      sr_v_q[0] <= s_acc;
      sr_u_q[0] <= s_acc & s_tuser;
      sr_l_q[0] <= s_acc & s_tlast;
      for (int i = 1; i < LATENCY; i++) begin
        sr_v_q[i] <= sr_v_q[i-1];
        sr_u_q[i] <= sr_u_q[i-1];
        sr_l_q[i] <= sr_l_q[i-1];
      end
    end
  end

  // A SOF beat takes the new view itself.
  always_comb begin
    view_d = view_q;
    if (tap_v && tap_u) view_d = view_sel;
  end

  // Active view register.
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) view_q <= BGM_VIEW_BG;
    else          view_q <= view_d;
  end

  // Output word for the captured beat.
  always_comb begin
    word = bg_in;
    if (view_d != BGM_VIEW_BG) begin
      word = {TDATA_WIDTH{bgm_view_mask(view_d, fg_in[0], mv_in[0])}};
    end
  end

`ifdef BGM_TX_SOF_ALIGN_EN
  bgm_sof_state_e state_q;
  bgm_sof_state_e state_d;
  logic           drop;
  logic           drop_q;

  // Capture-side alignment state and delayed credit return.
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      state_q <= SOF_WAIT;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      drop_q  <= drop;
    end
  end

  // Drop beats until the first SOF, then stream forever.
  always_comb begin
    state_d = state_q;
    wr_en   = 1'b0;
    drop    = 1'b0;
    unique case (state_q)
      SOF_WAIT: begin
        if (tap_v && tap_u) begin
          wr_en   = 1'b1;
          state_d = SOF_STREAM;
        end else if (tap_v) begin
          drop = 1'b1;
        end
      end
      SOF_STREAM: wr_en = tap_v;
      default: state_d = SOF_WAIT;
    endcase
  end

  assign credit_ret = drop_q;
`else
  assign wr_en      = tap_v;
  assign credit_ret = 1'b0;
`endif

  // Credit: reserve a slot on accept, free on drain or drop.
  always_comb begin
    credit_d = credit_q;
    if (out_hs)     credit_d = credit_d + CW'(1);
    if (credit_ret) credit_d = credit_d + CW'(1);
    if (s_acc)      credit_d = credit_d - CW'(1);
  end

  // Credit register and registered input ready.
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      credit_q   <= CW'(DEPTH);
      s_tready_q <= 1'b0;
    end else begin
      credit_q   <= credit_d;
      s_tready_q <= (credit_d != '0);
    end
  end

  bgm_sync_fifo #(
    .WIDTH (FW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (aresetn),
    .wr_en_i   (wr_en),
    .wr_data_i ({word, tap_u, tap_l}),
    .rd_en_i   (out_hs),
    .rd_data_o (rd_data),
    .full_o    (full_unused),
    .empty_o   (fifo_empty),
    .count_o   (count_unused)
  );

  assign {m_tdata, m_tuser, m_tlast} = rd_data;

endmodule
